// File: rtl/gray_bin_updown_counter.sv
// N-bit enabled up/down counter with binary or reflected-Gray output, parallel load and wrap/saturate control.
// Optional GRAY_CHECK_EN adds a registered gray_err flag for non-unit Gray steps.
module gray_bin_updown_counter #(
  parameter int WIDTH     = 4,
  parameter int RESET_IDX = 0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             up_dn,
  input  logic             gray_mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             sat,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap_pulse
`ifdef GRAY_CHECK_EN
  ,
  output logic             gray_err
`endif
);

  localparam logic [WIDTH-1:0] ALL_ONES  = '1;
  localparam logic [WIDTH-1:0] ZERO      = '0;
  localparam logic [WIDTH-1:0] RESET_VAL = WIDTH'(RESET_IDX);

  // Binary index bit i is the XOR of all Gray bits from the MSB down to i.
  function automatic logic [WIDTH-1:0] gray_decode(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b = '0;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [WIDTH-1:0] encode(input logic [WIDTH-1:0] idx,
                                              input logic             gm);
    return gm ? (idx ^ (idx >> 1)) : idx;
  endfunction

  logic [WIDTH-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic             at_top, at_bot;

  assign at_top = (idx_q == ALL_ONES);
  assign at_bot = (idx_q == ZERO);

  always_comb begin
    idx_d  = idx_q;
    wrap_d = 1'b0;
    if (load) begin
      idx_d = gray_mode ? gray_decode(load_val) : load_val;
    end else if (en) begin
      if (up_dn) begin
        if (at_top) begin
          if (!sat) begin
            idx_d  = ZERO;
            wrap_d = 1'b1;
          end
        end else begin
          idx_d = idx_q + WIDTH'(1);
        end
      end else begin
        if (at_bot) begin
          if (!sat) begin
            idx_d  = ALL_ONES;
            wrap_d = 1'b1;
          end
        end else begin
          idx_d = idx_q - WIDTH'(1);
        end
      end
    end
    // Re-encoding every edge lets a gray_mode change show up even while idle.
    q_d = encode(idx_d, gray_mode);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      idx_q  <= RESET_VAL;
      q_q    <= RESET_VAL;
      wrap_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  assign q          = q_q;
  assign wrap_pulse = wrap_q;
  assign tc         = up_dn ? at_top : at_bot;

`ifdef GRAY_CHECK_EN
  logic gm_prev_q;
  logic gray_err_q, gray_err_d;
  logic step_taken;

  // A step is a real count: not a load, and not parked at the terminal by sat.
  always_comb begin
    step_taken = ~load & en & ~(sat & (up_dn ? at_top : at_bot));
    gray_err_d = gray_mode & gm_prev_q & step_taken & ($countones(q_q ^ q_d) != 1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      gm_prev_q  <= 1'b0;
      gray_err_q <= 1'b0;
    end else begin
      gm_prev_q  <= gray_mode;
      gray_err_q <= gray_err_d;
    end
  end

  assign gray_err = gray_err_q;
`endif

endmodule

// File: tb/tb_gray_bin_updown_counter.sv
// Directed bench for gray_bin_updown_counter: driver pushes hand-computed {q, wrap_pulse, tc}
// into a queue, a negedge monitor pops and compares.
module tb_gray_bin_updown_counter;

  logic       clk;
  logic       rstn;
  logic       en;
  logic       up_dn;
  logic       gray_mode;
  logic       load;
  logic [3:0] load_val;
  logic       sat;
  logic [3:0] q;
  logic       tc;
  logic       wrap_pulse;
`ifdef GRAY_CHECK_EN
  logic       gray_err;
`endif

  int checks = 0;
  int errors = 0;

  logic [5:0] exp_q[$];
  string      name_q[$];
  logic [5:0] mon_e;
  string      mon_n;

  gray_bin_updown_counter #(.WIDTH(4), .RESET_IDX(0)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .en         (en),
    .up_dn      (up_dn),
    .gray_mode  (gray_mode),
    .load       (load),
    .load_val   (load_val),
    .sat        (sat),
    .q          (q),
    .tc         (tc),
    .wrap_pulse (wrap_pulse)
`ifdef GRAY_CHECK_EN
    ,
    .gray_err   (gray_err)
`endif
  );

  // clock/reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // monitor: each queued entry describes the outputs after one active edge
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_n = name_q.pop_front();
      checks++;
      if ({q, wrap_pulse, tc} !== mon_e) begin
        errors++;
        $display("FAIL %s: got q=%b wrap=%b tc=%b, expected q=%b wrap=%b tc=%b",
                 mon_n, q, wrap_pulse, tc, mon_e[5:2], mon_e[1], mon_e[0]);
      end
    end
  end

  // driver: apply inputs for one edge and queue the expected outputs after it
  task automatic step(input string nm, input logic e, input logic ud, input logic gm,
                      input logic ld, input logic [3:0] lv, input logic s,
                      input logic [3:0] eq, input logic ew, input logic et);
    en        = e;
    up_dn     = ud;
    gray_mode = gm;
    load      = ld;
    load_val  = lv;
    sat       = s;
    exp_q.push_back({eq, ew, et});
    name_q.push_back(nm);
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  // asynchronous reset between edges; checked without any clock edge
  task automatic async_reset(input string nm);
    #1 rstn = 1'b0;
    #1;
    checks++;
    if ({q, wrap_pulse, tc} !== 6'b0000_0_0) begin
      errors++;
      $display("FAIL %s: got q=%b wrap=%b tc=%b, expected q=0000 wrap=0 tc=0",
               nm, q, wrap_pulse, tc);
    end
    @(negedge clk);
    #1 rstn = 1'b1;
  endtask

  logic [3:0] gray_seq [16];

  initial begin
    gray_seq = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100,
                 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};
    rstn      = 1'b0;
    en        = 1'b0;
    up_dn     = 1'b1;
    gray_mode = 1'b1;
    load      = 1'b0;
    load_val  = 4'b0000;
    sat       = 1'b0;
    #3;
    checks++;
    if ({q, wrap_pulse, tc} !== 6'b0000_0_0) begin
      errors++;
      $display("FAIL reset_init: got q=%b wrap=%b tc=%b, expected q=0000 wrap=0 tc=0",
               q, wrap_pulse, tc);
    end
    @(negedge clk);
    #1 rstn = 1'b1;

    // Gray up through a full cycle and wrap
    for (int k = 0; k < 16; k++) begin
      step("gray_up", 1, 1, 1, 0, 4'b0000, 0, gray_seq[k], (k == 15), (k == 14));
    end
    async_reset("reset_clears_wrap");

    // binary down from 0: wrap, then saturate
    step("bin_down_wrap",  1, 0, 0, 0, 4'b0000, 0, 4'b1111, 1, 0);
    step("bin_load_zero",  0, 0, 0, 1, 4'b0000, 0, 4'b0000, 0, 1);
    step("bin_down_sat1",  1, 0, 0, 0, 4'b0000, 1, 4'b0000, 0, 1);
    step("bin_down_sat2",  1, 0, 0, 0, 4'b0000, 1, 4'b0000, 0, 1);

    // Gray load beats en, then step
    step("gray_load_win",  1, 1, 1, 1, 4'b0110, 0, 4'b0110, 0, 0);
    step("gray_load_step", 1, 1, 1, 0, 4'b0000, 0, 4'b0111, 0, 0);

    // mode switch while idle
    step("mode_bin",       0, 1, 0, 0, 4'b0000, 0, 4'b0101, 0, 0);
    step("mode_gray",      0, 1, 1, 0, 4'b0000, 0, 4'b0111, 0, 0);
    step("mode_bin_back",  0, 1, 0, 0, 4'b0000, 0, 4'b0101, 0, 0);

    // en gating
    for (int k = 0; k < 3; k++) begin
      step("en_hold", 0, 1, 0, 0, 4'b1111, 0, 4'b0101, 0, 0);
    end

    // direction reversal every edge from 7
    step("rev_load7",      0, 1, 0, 1, 4'b0111, 0, 4'b0111, 0, 0);
    step("rev_up8",        1, 1, 0, 0, 4'b0000, 0, 4'b1000, 0, 0);
    step("rev_dn7",        1, 0, 0, 0, 4'b0000, 0, 4'b0111, 0, 0);
    step("rev_up8b",       1, 1, 0, 0, 4'b0000, 0, 4'b1000, 0, 0);
    step("rev_dn7b",       1, 0, 0, 0, 4'b0000, 0, 4'b0111, 0, 0);

    // binary up at all-ones: saturate, then wrap, then pulse clears
    step("up_load15",      0, 1, 0, 1, 4'b1111, 1, 4'b1111, 0, 1);
    step("up_sat_hold",    1, 1, 0, 0, 4'b0000, 1, 4'b1111, 0, 1);
    step("up_wrap",        1, 1, 0, 0, 4'b0000, 0, 4'b0000, 1, 0);
    step("wrap_clear",     0, 1, 0, 0, 4'b0000, 0, 4'b0000, 0, 0);

    // Gray load of 1000 decodes to index 15; Gray down wrap from 0
    step("gray_load15",    0, 1, 1, 1, 4'b1000, 0, 4'b1000, 0, 1);
    step("gray_up_wrap",   1, 1, 1, 0, 4'b0000, 0, 4'b0000, 1, 0);
    step("gray_dn_wrap",   1, 0, 1, 0, 4'b0000, 0, 4'b1000, 1, 0);
    step("gray_dn14",      1, 0, 1, 0, 4'b0000, 0, 4'b1001, 0, 0);

    // mid-count reset at 1010, then resume from 0
    step("load_1010",      0, 1, 0, 1, 4'b1010, 0, 4'b1010, 0, 0);
    async_reset("reset_mid_count");
    step("resume_up",      1, 1, 0, 0, 4'b0000, 0, 4'b0001, 0, 0);

    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
